// File: rtl/fft_stage_5.sv
// rtl/fft_stage_5.sv - final radix-2 butterfly between consecutive 16-lane blocks
// Emits U=A+B then V=tw(A-B); tw is -j on odd pairs within a frame.
module fft_stage_5 #(
  parameter int DATA       = 14,
  parameter int ARRAY      = 16,
  parameter int FRAME_BLKS = 32
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        valid_in,
  input  logic [ARRAY-1:0][DATA-1:0]  din_re,
  input  logic [ARRAY-1:0][DATA-1:0]  din_im,
  output logic                        valid_out,
  output logic [ARRAY-1:0][DATA:0]    dout_re,
  output logic [ARRAY-1:0][DATA:0]    dout_im,
  output logic                        frame_start
);

  localparam int PAIRS = FRAME_BLKS / 2;
  localparam int PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int W     = DATA + 1;

  logic [ARRAY-1:0][DATA-1:0] dr_re, dr_im, a_re, a_im;
  logic [ARRAY-1:0][W-1:0]    u_re, u_im, v_re, v_im, vh_re, vh_im;
  logic                       vld_reg, phase, v_pend;
  logic [PW-1:0]              pair_cnt, pair_nxt;

  assign pair_nxt = (pair_cnt == PW'(PAIRS - 1)) ? '0 : pair_cnt + PW'(1);

  // Sign-extend to W bits first so sum/difference never wrap.
  genvar l;
  generate
    for (l = 0; l < ARRAY; l++) begin : g_lane
      logic signed [W-1:0] ar, ai, br, bi, df_re, df_im;
      assign ar    = {a_re[l][DATA-1], a_re[l]};
      assign ai    = {a_im[l][DATA-1], a_im[l]};
      assign br    = {dr_re[l][DATA-1], dr_re[l]};
      assign bi    = {dr_im[l][DATA-1], dr_im[l]};
      assign u_re[l] = ar + br;
      assign u_im[l] = ai + bi;
      assign df_re = ar - br;
      assign df_im = ai - bi;
      assign v_re[l] = pair_cnt[0] ? df_im : df_re;
      assign v_im[l] = pair_cnt[0] ? -df_re : df_im;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dr_re       <= '0;
      dr_im       <= '0;
      vld_reg     <= 1'b0;
      a_re        <= '0;
      a_im        <= '0;
      vh_re       <= '0;
      vh_im       <= '0;
      phase       <= 1'b0;
      v_pend      <= 1'b0;
      pair_cnt    <= '0;
      valid_out   <= 1'b0;
      frame_start <= 1'b0;
      dout_re     <= '0;
      dout_im     <= '0;
    end else begin
      dr_re   <= din_re;
      dr_im   <= din_im;
      vld_reg <= valid_in;

      // A capture runs alongside the V drain that follows a U block.
      if (vld_reg && !phase) begin
        a_re  <= dr_re;
        a_im  <= dr_im;
        phase <= 1'b1;
      end

      if (vld_reg && phase) begin
        dout_re     <= u_re;
        dout_im     <= u_im;
        vh_re       <= v_re;
        vh_im       <= v_im;
        v_pend      <= 1'b1;
        phase       <= 1'b0;
        valid_out   <= 1'b1;
        frame_start <= (pair_cnt == '0);
        pair_cnt    <= pair_nxt;
      end else if (v_pend) begin
        dout_re     <= vh_re;
        dout_im     <= vh_im;
        valid_out   <= 1'b1;
        frame_start <= 1'b0;
        v_pend      <= 1'b0;
      end else begin
        valid_out   <= 1'b0;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_stage_5.sv
// tb/tb_fft_stage_5.sv - directed vector bench for fft_stage_5
module tb_fft_stage_5;

  localparam int DATA  = 14;
  localparam int ARRAY = 16;
  localparam int NSTR  = 64;

  logic                       clk = 1'b0;
  logic                       rstn;
  logic                       valid_in;
  logic [ARRAY-1:0][DATA-1:0] din_re, din_im;
  logic                       valid_out;
  logic [ARRAY-1:0][DATA:0]   dout_re, dout_im;
  logic                       frame_start;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int a_re, a_im, b_re, b_im;
    int u_re, u_im, v_re, v_im;
    bit fs;
  } vec_t;

  vec_t tbl[6];
  int   sr[NSTR][ARRAY];
  int   si[NSTR][ARRAY];
  int   er[ARRAY];
  int   ei[ARRAY];

  fft_stage_5 #(.DATA(DATA), .ARRAY(ARRAY), .FRAME_BLKS(32)) dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in),
    .din_re(din_re), .din_im(din_im),
    .valid_out(valid_out), .dout_re(dout_re), .dout_im(dout_im),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_uni(input bit v, input int re, input int im);
    valid_in = v;
    for (int k = 0; k < ARRAY; k++) begin
      din_re[k] = DATA'(re);
      din_im[k] = DATA'(im);
    end
  endtask

  task automatic chk_bit(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk_arr(input string nm);
    int gr, gi;
    bit bad;
    bad = 1'b0;
    n_chk++;
    for (int k = 0; k < ARRAY && !bad; k++) begin
      gr = int'($signed(dout_re[k]));
      gi = int'($signed(dout_im[k]));
      if (gr != er[k] || gi != ei[k] || $isunknown(dout_re[k]) || $isunknown(dout_im[k])) begin
        bad = 1'b1;
        n_fail++;
        $display("FAIL %s lane %0d: got re=%0d im=%0d expected re=%0d im=%0d",
                 nm, k, gr, gi, er[k], ei[k]);
      end
    end
  endtask

  task automatic chk_uni(input string nm, input int re, input int im);
    for (int k = 0; k < ARRAY; k++) begin
      er[k] = re;
      ei[k] = im;
    end
    chk_arr(nm);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    drive_uni(1'b0, 0, 0);
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    tbl[0] = '{100, -50, 30, 20, 130, -30, 70, -70, 1'b1};
    tbl[1] = '{100, -50, 30, 20, 130, -30, -70, -70, 1'b0};
    tbl[2] = '{-8192, -8192, 8191, 8191, -1, -1, -16383, -16383, 1'b0};
    tbl[3] = '{8191, 8191, -8192, -8192, -1, -1, 16383, -16383, 1'b0};
    tbl[4] = '{-8192, 8191, 8191, -8192, -1, -1, -16383, 16383, 1'b0};
    tbl[5] = '{1234, -4321, -567, 890, 667, -3431, -5211, -1801, 1'b0};

    // Reset held with valid input: outputs must stay cleared.
    rstn = 1'b0;
    drive_uni(1'b1, 123, -77);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_bit($sformatf("rst_valid_%0d", c), valid_out, 1'b0);
      chk_bit($sformatf("rst_fs_%0d", c), frame_start, 1'b0);
      chk_uni($sformatf("rst_dout_%0d", c), 0, 0);
    end
    rstn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      drive_uni(1'b1, tbl[i].a_re, tbl[i].a_im);
      tick();
      drive_uni(1'b1, tbl[i].b_re, tbl[i].b_im);
      tick();
      drive_uni(1'b0, 0, 0);
      tick();
      chk_bit($sformatf("vec%0d_u_valid", i), valid_out, 1'b1);
      chk_uni($sformatf("vec%0d_u", i), tbl[i].u_re, tbl[i].u_im);
      chk_bit($sformatf("vec%0d_u_fs", i), frame_start, tbl[i].fs);
      tick();
      chk_bit($sformatf("vec%0d_v_valid", i), valid_out, 1'b1);
      chk_uni($sformatf("vec%0d_v", i), tbl[i].v_re, tbl[i].v_im);
      chk_bit($sformatf("vec%0d_v_fs", i), frame_start, 1'b0);
      tick();
      chk_bit($sformatf("vec%0d_idle", i), valid_out, 1'b0);
    end

    // Gap between A and B (pair 6, even).
    drive_uni(1'b1, 100, -50);
    tick();
    drive_uni(1'b0, 999, 999);
    for (int g = 0; g < 3; g++) begin
      tick();
      chk_bit($sformatf("gap_idle_%0d", g), valid_out, 1'b0);
    end
    drive_uni(1'b1, 30, 20);
    tick();
    drive_uni(1'b0, 0, 0);
    tick();
    chk_bit("gap_u_valid", valid_out, 1'b1);
    chk_uni("gap_u", 130, -30);
    chk_bit("gap_u_fs", frame_start, 1'b0);
    tick();
    chk_bit("gap_v_valid", valid_out, 1'b1);
    chk_uni("gap_v", 70, -70);
    tick();

    // Reset after A is captured: A must be discarded.
    drive_uni(1'b1, 500, 500);
    tick();
    drive_uni(1'b0, 0, 0);
    tick();
    rstn = 1'b0;
    tick();
    chk_bit("midrst_valid", valid_out, 1'b0);
    rstn = 1'b1;
    drive_uni(1'b1, 100, -50);
    tick();
    drive_uni(1'b1, 30, 20);
    tick();
    drive_uni(1'b0, 0, 0);
    tick();
    chk_bit("midrst_u_valid", valid_out, 1'b1);
    chk_uni("midrst_u", 130, -30);
    chk_bit("midrst_u_fs", frame_start, 1'b1);
    tick();
    chk_uni("midrst_v", 70, -70);
    tick();

    // Back-to-back streaming across a frame wrap.
    do_reset();
    for (int b = 0; b < NSTR; b++)
      for (int k = 0; k < ARRAY; k++) begin
        sr[b][k] = int'($urandom_range(0, 16383)) - 8192;
        si[b][k] = int'($urandom_range(0, 16383)) - 8192;
      end
    for (int t = 0; t < NSTR + 4; t++) begin
      if (t < NSTR) begin
        valid_in = 1'b1;
        for (int k = 0; k < ARRAY; k++) begin
          din_re[k] = DATA'(sr[t][k]);
          din_im[k] = DATA'(si[t][k]);
        end
      end else begin
        drive_uni(1'b0, 0, 0);
      end
      tick();
      if (t >= 2 && t - 2 < NSTR) begin
        int j, p;
        j = t - 2;
        p = j / 2;
        for (int k = 0; k < ARRAY; k++) begin
          int d_re, d_im;
          if (j % 2 == 0) begin
            er[k] = sr[2*p][k] + sr[2*p+1][k];
            ei[k] = si[2*p][k] + si[2*p+1][k];
          end else begin
            d_re = sr[2*p][k] - sr[2*p+1][k];
            d_im = si[2*p][k] - si[2*p+1][k];
            er[k] = (p % 2 == 1) ? d_im : d_re;
            ei[k] = (p % 2 == 1) ? -d_re : d_im;
          end
        end
        chk_bit($sformatf("str%0d_valid", j), valid_out, 1'b1);
        chk_arr($sformatf("str%0d_data", j));
        chk_bit($sformatf("str%0d_fs", j), frame_start,
                (j % 2 == 0) && ((p % 16) == 0));
      end else if (t >= NSTR + 2) begin
        chk_bit($sformatf("str_tail_%0d", t), valid_out, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
